// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, computed LSB-first one bit per clock
// through a single full-subtractor cell with a registered borrow.
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - operands a/b valid
//   in_ready  - operands accepted (high only while idle)
//   a, b      - minuend / subtrahend, WIDTH bits, unsigned
//   out_valid - diff/borrow valid (high only while a result is presented)
//   out_ready - consumer accepts the result
//   diff      - (a - b) mod 2^WIDTH
//   borrow    - final borrow-out, 1 iff a < b
//   busy      - high while bits are being processed
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sd_q, sd_d;
  logic             br_q, br_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Full-subtractor cell on the current LSBs.
  logic d_bit;
  logic br_next;
  assign d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sd_d    = sd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sd_d = {d_bit, sd_q[WIDTH-1:1]};
        sa_d = {1'b0, sa_q[WIDTH-1:1]};
        sb_d = {1'b0, sb_q[WIDTH-1:1]};
        br_d = br_next;
        // Counter parks at the last index rather than wrapping.
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sd_q    <= sd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from registered state only.
  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign diff      = sd_q;
  assign borrow    = br_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8). Expected results come from a
// 9-bit reference subtraction, queued when operands are driven and popped on out_valid.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         br;
    logic [W-1:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'd0);
    check({tag, "_borrow"}, 32'(borrow), 32'd0);
  endtask

  // One full transaction. hold = cycles of out_ready=0 in DONE; pulse = drive a stray
  // in_valid with other operands during RUN.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold,
                       input bit pulse);
    exp_t       e;
    logic [W:0] full;
    int         lat;
    int         busy_cnt;
    full = {1'b0, ta} - {1'b0, tb_v};
    e.br = full[W];
    e.d  = full[W-1:0];
    sb_q.push_back(e);

    @(negedge clk);
    a         = ta;
    b         = tb_v;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);  // acceptance edge E0
    #1 in_valid = 1'b0;

    lat      = 0;
    busy_cnt = 0;
    @(negedge clk);
    if (busy) busy_cnt++;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy) busy_cnt++;
      check("excl_ready_valid", 32'(in_ready & out_valid), 32'd0);
      if (lat == 2) check("in_ready_run", 32'(in_ready), 32'd0);
      if (pulse && lat == 3) begin
        in_valid = 1'b1;
        a        = 8'h01;
        b        = 8'h02;
      end else if (pulse && lat == 4) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("out_valid", 32'(out_valid), 32'd1);

    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("diff", 32'(diff), 32'(e.d));
      check("borrow", 32'(borrow), 32'(e.br));
    end else begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_diff", 32'(diff), 32'(e.d));
      check("hold_borrow", 32'(borrow), 32'(e.br));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("consumed_out_valid", 32'(out_valid), 32'd0);
    check("consumed_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    do_op(8'h5A, 8'h13, 0, 1'b0);
    do_op(8'h13, 8'h5A, 0, 1'b0);
    do_op(8'h00, 8'h01, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 0, 1'b0);
    do_op(8'h80, 8'h00, 0, 1'b0);
    do_op(8'h5A, 8'h13, 5, 1'b0);
    do_op(8'h5A, 8'h13, 0, 1'b1);

    // Abort 0x5A - 0x13 after four RUN edges with an asynchronous reset.
    @(negedge clk);
    a         = 8'h5A;
    b         = 8'h13;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort_release");

    do_op(8'h10, 8'h01, 0, 1'b0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes `diff = a - b` LSB-first, one bit per clock, using a single full-subtractor cell and a registered borrow. It is the subtraction counterpart to the team's adder cells and is intended for area-constrained datapaths that can tolerate multi-cycle latency. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake with backpressure.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands `a`/`b` are valid.
- `in_ready`  output  1  block can accept operands; high only in IDLE.
- `a`  input  WIDTH  minuend, unsigned.
- `b`  input  WIDTH  subtrahend, unsigned.
- `out_valid`  output  1  `diff`/`borrow` are valid; high only in DONE.
- `out_ready`  input  1  consumer accepts the result.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow`  output  1  final borrow-out; 1 iff `a < b` (unsigned).
- `busy`  output  1  high in RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready` at a rising edge: load `a` and `b` into shift registers SA and SB, clear the borrow flop `br` and bit counter `cnt`, then go to RUN.
- RUN, one bit per cycle:
  - `d = SA[0] ^ SB[0] ^ br`.
  - `br_next = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & br)`.
  - Shift `d` into the MSB of result register SD, with SD shifting right.
  - Shift SA and SB right.
  - Increment `cnt`.
  - When `cnt == WIDTH-1` at the edge, the last bit is processed and the state goes to DONE.
- DONE:
  - `out_valid` = 1.
  - `diff` = SD and `borrow` = `br`, both held stable.
  - On `out_valid && out_ready` at a rising edge, go to IDLE.
- `in_valid` is ignored in RUN and DONE. No operand is captured, and the in-flight computation is unaffected.
- `cnt` width is `$clog2(WIDTH)`. It never wraps past `WIDTH-1` during an operation.
- `diff` is driven directly from SD. It may change during RUN and is meaningful only while `out_valid` = 1.
- Control outputs are decoded from the registered state only. There are no combinational paths from inputs to outputs.

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - State = IDLE.
  - SA, SB, SD, `br` and `cnt` = 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `diff` = 0, `borrow` = 0.
- Reset asserted mid-RUN or mid-DONE immediately aborts the operation. No result is presented, and the block is in IDLE once `rst_n` deasserts.
- Latency:
  - Operands are accepted at edge E0.
  - Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
  - `out_valid` is high from just after E_WIDTH, i.e. WIDTH cycles after acceptance.
- Backpressure: while `out_ready` = 0 in DONE, the block holds DONE indefinitely with outputs frozen.
- Result consumed at edge Ec → IDLE after Ec, with `in_ready` = 1 in the next cycle.
- Throughput: with `out_ready` tied high, minimum issue period is WIDTH+2 cycles (IDLE, WIDTH × RUN, DONE).
- `in_ready` and `out_valid` are never simultaneously high.

## Test plan
- WIDTH=8, a=0x5A, b=0x13 → `out_valid` exactly 8 cycles after accept, `diff`=0x47, `borrow`=0; `busy` high for exactly 8 cycles.
- a=0x13, b=0x5A → `diff`=0xB9, `borrow`=1. Also a=0x00, b=0x01 → `diff`=0xFF, `borrow`=1 (borrow ripples through all bits).
- a=0xFF, b=0xFF → `diff`=0x00, `borrow`=0. Also a=0x80, b=0x00 → `diff`=0x80, `borrow`=0.
- Hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `diff` and `borrow` stay stable and `in_ready` stays 0; raise `out_ready` → IDLE next cycle.
- Pulse `in_valid` with a=0x01, b=0x02 during RUN of a 0x5A−0x13 operation → ignored; result is still 0x47 and `borrow`=0.
- Assert `rst_n`=0 at RUN cycle 4 → outputs go to reset values immediately. After release, a fresh 0x10−0x01 produces `diff`=0x0F, `borrow`=0, with no residue from the aborted operation.
